// File: rtl/jtag_reg_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_reg_access_arbiter_if
// Purpose  : Bundles the JTAG request path (toggle handshake), the local user
//            request path (req/gnt), the register-file port and the sticky
//            error flags of jtag_reg_access_arbiter.
// Modports : slave  - the arbiter (consumes requests, drives reg port/acks)
//            master - the environment (TAP side, user logic, register file)
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_reg_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // JTAG (tck-domain) request path
    logic              jtag_req_tgl;
    logic              jtag_wr;
    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] jtag_wdata;
    logic              jtag_ack_tgl;
    logic [DATA_W-1:0] jtag_rdata;
    // Local user request path
    logic              usr_req;
    logic              usr_wr;
    logic [ADDR_W-1:0] usr_addr;
    logic [DATA_W-1:0] usr_wdata;
    logic              usr_gnt;
    logic [DATA_W-1:0] usr_rdata;
    // Shared register-file port
    logic              reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    // Sticky error flags
    logic              err_addr;
    logic              err_proto;

    modport slave (
        input  jtag_req_tgl, jtag_wr, jtag_addr, jtag_wdata,
        output jtag_ack_tgl, jtag_rdata,
        input  usr_req, usr_wr, usr_addr, usr_wdata,
        output usr_gnt, usr_rdata,
        output reg_we, reg_addr, reg_wdata,
        input  reg_rdata,
        output err_addr, err_proto
    );

    modport master (
        output jtag_req_tgl, jtag_wr, jtag_addr, jtag_wdata,
        input  jtag_ack_tgl, jtag_rdata,
        output usr_req, usr_wr, usr_addr, usr_wdata,
        input  usr_gnt, usr_rdata,
        input  reg_we, reg_addr, reg_wdata,
        output reg_rdata,
        input  err_addr, err_proto
    );
endinterface
`default_nettype wire

// File: rtl/jtag_reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jtag_reg_access_arbiter
// Purpose  : Synchronizes toggle-handshake JTAG register requests into the
//            clk domain and arbitrates them round-robin against a local user
//            requester for a single register-file port. Each access takes
//            three clk cycles (IDLE, GNT, ACK) and returns the pre-write
//            contents of the addressed register.
// Ports    : clk  - user clock
//            trst - asynchronous active-high reset (shared with the TAP)
//            bus  - jtag_reg_access_arbiter_if.slave: JTAG request/ack,
//                   user req/gnt, register-file port, sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module jtag_reg_access_arbiter #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] BAD_RDATA   = 32'hBAD0_ADD0
) (
    input  wire logic                  clk,
    input  wire logic                  trst,
    jtag_reg_access_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GNT_J = 3'd1,
        ST_GNT_U = 3'd2,
        ST_ACK_J = 3'd3,
        ST_ACK_U = 3'd4
    } state_t;

    localparam logic C_WIN_USER = 1'b0;
    localparam logic C_WIN_JTAG = 1'b1;

    state_t                   state_q;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     sync_prev_q;
    logic                     jtag_pend_q;
    logic                     last_winner_q;
    logic [DATA_W-1:0]        data_q;
    logic                     jtag_ack_tgl_q;
    logic [DATA_W-1:0]        jtag_rdata_q;
    logic                     usr_gnt_q;
    logic [DATA_W-1:0]        usr_rdata_q;
    logic                     err_addr_q;
    logic                     err_proto_q;

    logic                     w_tgl_edge;
    logic                     w_sel_wr;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic [DATA_W-1:0]        w_sel_wdata;
    logic                     w_in_range;
    logic [DATA_W-1:0]        w_rdata_sel;

    // Each change of the synchronized toggle level is one new JTAG request.
    assign w_tgl_edge = sync_q[SYNC_STAGES-1] ^ sync_prev_q;

    // The register port is driven straight from the granted requester during
    // the GNT cycle so the combinational register file returns the old
    // contents in that same cycle (read-before-write). Outside GNT the port
    // is parked at zero, and an async trst clears it immediately.
    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        case (state_q)
            ST_GNT_J: begin
                w_sel_wr    = bus.jtag_wr;
                w_sel_addr  = bus.jtag_addr;
                w_sel_wdata = bus.jtag_wdata;
            end
            ST_GNT_U: begin
                w_sel_wr    = bus.usr_wr;
                w_sel_addr  = bus.usr_addr;
                w_sel_wdata = bus.usr_wdata;
            end
            default: ;
        endcase
        w_in_range  = (w_sel_addr < ADDR_W'(NUM_REGS));
        w_rdata_sel = w_in_range ? bus.reg_rdata : BAD_RDATA;
    end

    assign bus.reg_we       = w_sel_wr & w_in_range;
    assign bus.reg_addr     = w_sel_addr;
    assign bus.reg_wdata    = w_sel_wdata;
    assign bus.jtag_ack_tgl = jtag_ack_tgl_q;
    assign bus.jtag_rdata   = jtag_rdata_q;
    assign bus.usr_gnt      = usr_gnt_q;
    assign bus.usr_rdata    = usr_rdata_q;
    assign bus.err_addr     = err_addr_q;
    assign bus.err_proto    = err_proto_q;

    always_ff @(posedge clk or posedge trst) begin
        if (trst) begin
            state_q        <= ST_IDLE;
            sync_q         <= '0;
            sync_prev_q    <= 1'b0;
            jtag_pend_q    <= 1'b0;
            last_winner_q  <= C_WIN_USER;
            data_q         <= '0;
            jtag_ack_tgl_q <= 1'b0;
            jtag_rdata_q   <= '0;
            usr_gnt_q      <= 1'b0;
            usr_rdata_q    <= '0;
            err_addr_q     <= 1'b0;
            err_proto_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.jtag_req_tgl};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            usr_gnt_q   <= 1'b0;

            // A second request before the first is acknowledged breaks the
            // toggle protocol; it is dropped and flagged.
            if (w_tgl_edge) begin
                if (jtag_pend_q) begin
                    err_proto_q <= 1'b1;
                end else begin
                    jtag_pend_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (jtag_pend_q && bus.usr_req) begin
                        state_q <= (last_winner_q == C_WIN_USER) ? ST_GNT_J : ST_GNT_U;
                    end else if (jtag_pend_q) begin
                        state_q <= ST_GNT_J;
                    end else if (bus.usr_req) begin
                        state_q <= ST_GNT_U;
                    end
                end
                ST_GNT_J: begin
                    data_q        <= w_rdata_sel;
                    last_winner_q <= C_WIN_JTAG;
                    if (!w_in_range) begin
                        err_addr_q <= 1'b1;
                    end
                    state_q       <= ST_ACK_J;
                end
                ST_GNT_U: begin
                    // Loaded here so usr_rdata is already valid while usr_gnt
                    // is high during ACK_U.
                    usr_rdata_q   <= w_rdata_sel;
                    usr_gnt_q     <= 1'b1;
                    last_winner_q <= C_WIN_USER;
                    if (!w_in_range) begin
                        err_addr_q <= 1'b1;
                    end
                    state_q       <= ST_ACK_U;
                end
                ST_ACK_J: begin
                    jtag_rdata_q   <= data_q;
                    jtag_ack_tgl_q <= ~jtag_ack_tgl_q;
                    jtag_pend_q    <= 1'b0;
                    state_q        <= ST_IDLE;
                end
                ST_ACK_U: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
